// File: rtl/hazard3_ifetch_ahbl_pkg.sv
// Shared hazard3 AHB-Lite bus constants.
//   htrans_e    : AHB transfer types driven by the fetch bridge (IDLE / NONSEQ only)
//   HSIZE_HALF  : 16-bit transfer size encoding
//   HSIZE_WORD  : 32-bit transfer size encoding
package hazard3_ifetch_ahbl_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   function automatic logic [2:0] hsize_of(input logic word);
      return word ? HSIZE_WORD : HSIZE_HALF;
   endfunction

endpackage

// File: rtl/hazard3_ifetch_ahbl_if.sv
// Signal bundle between the fetch frontend, the fetch bridge and the AHB-Lite bus.
//   mem_*  : frontend fetch port (address valid/ready, single-cycle data strobe)
//   i_h*   : AHB-Lite manager port
// Modports:
//   master : the bridge (drives AHB request and frontend responses)
//   slave  : the environment (frontend + AHB subordinate)
interface hazard3_ifetch_ahbl_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              mem_size;
   logic [W_ADDR-1:0] mem_addr;
   logic              mem_priv;
   logic              mem_addr_vld;
   logic              mem_addr_rdy;
   logic [W_DATA-1:0] mem_data;
   logic              mem_data_err;
   logic              mem_data_vld;

   logic [W_ADDR-1:0] i_haddr;
   logic              i_hwrite;
   logic [1:0]        i_htrans;
   logic [2:0]        i_hsize;
   logic [2:0]        i_hburst;
   logic [3:0]        i_hprot;
   logic              i_hmastlock;
   logic              i_hready;
   logic              i_hresp;
   logic [W_DATA-1:0] i_hrdata;

   modport master (
      input  mem_size, mem_addr, mem_priv, mem_addr_vld,
      output mem_addr_rdy, mem_data, mem_data_err, mem_data_vld,
      output i_haddr, i_hwrite, i_htrans, i_hsize, i_hburst, i_hprot, i_hmastlock,
      input  i_hready, i_hresp, i_hrdata
   );

   modport slave (
      output mem_size, mem_addr, mem_priv, mem_addr_vld,
      input  mem_addr_rdy, mem_data, mem_data_err, mem_data_vld,
      input  i_haddr, i_hwrite, i_htrans, i_hsize, i_hburst, i_hprot, i_hmastlock,
      output i_hready, i_hresp, i_hrdata
   );
endinterface

// File: rtl/hazard3_ifetch_ahbl.sv
// Instruction-fetch bridge: frontend address valid/ready + data strobe to a
// single AHB-Lite manager port, at most one data phase outstanding.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard3_ifetch_ahbl_if.master (frontend fetch port + AHB-Lite port)
// Build option:
//   HAZARD3_IFETCH_ADDR_HOLD_EN : latch a stalled address phase so it stays
//   stable if the frontend retracts/changes its request; the response of a
//   transfer nobody wants any more is discarded.
module hazard3_ifetch_ahbl
   import hazard3_ifetch_ahbl_pkg::*;
#(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   hazard3_ifetch_ahbl_if.master      bus
);

   logic              dph_vld_q, dph_vld_d;
   logic              err1_q, err1_d;
   logic              dph_orphan;

   logic              err_first;
   logic              aph_done;
   logic              up_match;
   logic              req_vld;
   logic [W_ADDR-1:0] req_addr;
   logic              req_size;
   logic              req_priv;
   htrans_e           htrans;
   logic [W_DATA-1:0] rdata_gated;
   logic              data_vld;

   // Second-to-last cycle of a two-cycle error response: no new address
   // phase may be presented here.
   assign err_first = dph_vld_q & bus.i_hresp & ~bus.i_hready;
   assign htrans    = (req_vld && !err_first) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign aph_done  = (htrans == HTRANS_NONSEQ) && bus.i_hready;

`ifdef HAZARD3_IFETCH_ADDR_HOLD_EN
   logic              hold_vld_q, hold_vld_d;
   logic [W_ADDR-1:0] hold_addr_q, hold_addr_d;
   logic              hold_size_q, hold_size_d;
   logic              hold_priv_q, hold_priv_d;
   logic              dph_orphan_q, dph_orphan_d;

   assign req_vld  = hold_vld_q | bus.mem_addr_vld;
   assign req_addr = hold_vld_q ? hold_addr_q : bus.mem_addr;
   assign req_size = hold_vld_q ? hold_size_q : bus.mem_size;
   assign req_priv = hold_vld_q ? hold_priv_q : bus.mem_priv;
   assign up_match = !hold_vld_q ||
                     (bus.mem_addr == hold_addr_q && bus.mem_size == hold_size_q &&
                      bus.mem_priv == hold_priv_q);

   always_comb begin
      hold_vld_d   = hold_vld_q;
      hold_addr_d  = hold_addr_q;
      hold_size_d  = hold_size_q;
      hold_priv_d  = hold_priv_q;
      dph_orphan_d = dph_orphan_q;
      if (err_first || bus.i_hready) begin
         hold_vld_d = 1'b0;
      end else if (htrans == HTRANS_NONSEQ && !hold_vld_q) begin
         hold_vld_d  = 1'b1;
         hold_addr_d = bus.mem_addr;
         hold_size_d = bus.mem_size;
         hold_priv_d = bus.mem_priv;
      end
      // A held transfer that completes without the frontend still asking
      // for it gets a data phase whose response nobody will consume.
      if (bus.i_hready) begin
         dph_orphan_d = aph_done && hold_vld_q && !(bus.mem_addr_vld && up_match);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld_q   <= 1'b0;
         hold_addr_q  <= '0;
         hold_size_q  <= 1'b0;
         hold_priv_q  <= 1'b0;
         dph_orphan_q <= 1'b0;
      end else begin
         hold_vld_q   <= hold_vld_d;
         hold_addr_q  <= hold_addr_d;
         hold_size_q  <= hold_size_d;
         hold_priv_q  <= hold_priv_d;
         dph_orphan_q <= dph_orphan_d;
      end
   end

   assign dph_orphan = dph_orphan_q;
`else
   assign req_vld    = bus.mem_addr_vld;
   assign req_addr   = bus.mem_addr;
   assign req_size   = bus.mem_size;
   assign req_priv   = bus.mem_priv;
   assign up_match   = 1'b1;
   assign dph_orphan = 1'b0;
`endif

   always_comb begin
      dph_vld_d = dph_vld_q;
      err1_d    = err1_q;
      if (bus.i_hready) begin
         dph_vld_d = aph_done;
      end
      if (err_first) begin
         err1_d = 1'b1;
      end else if (bus.i_hready) begin
         err1_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_vld_q <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         dph_vld_q <= dph_vld_d;
         err1_q    <= err1_d;
      end
   end

   assign data_vld    = dph_vld_q & bus.i_hready & ~dph_orphan;
   assign rdata_gated = data_vld ? bus.i_hrdata : '0;

   assign bus.mem_addr_rdy = bus.i_hready & bus.mem_addr_vld & ~err_first & up_match;
   assign bus.mem_data_vld = data_vld;
   assign bus.mem_data     = rdata_gated;
   assign bus.mem_data_err = data_vld & bus.i_hresp;

   assign bus.i_htrans    = htrans;
   assign bus.i_haddr     = (htrans == HTRANS_NONSEQ) ? req_addr : '0;
   assign bus.i_hsize     = hsize_of(req_size);
   assign bus.i_hprot     = {2'b00, req_priv, 1'b0};
   assign bus.i_hwrite    = 1'b0;
   assign bus.i_hmastlock = 1'b0;
   assign bus.i_hburst    = 3'b000;

`ifdef FORMAL
   // The second error cycle must still carry HRESP=1.
   always @(posedge clk) begin
      if (rst_n && err1_q && bus.i_hready) begin
         assert (bus.i_hresp);
      end
   end
`ifndef HAZARD3_IFETCH_ADDR_HOLD_EN
   // Without the hold registers the frontend must keep a stalled request stable.
   always @(posedge clk) begin
      if (rst_n && $past(rst_n) && $past(bus.mem_addr_vld && !bus.mem_addr_rdy)) begin
         assert (bus.mem_addr_vld && bus.mem_addr == $past(bus.mem_addr) &&
                 bus.mem_size == $past(bus.mem_size) && bus.mem_priv == $past(bus.mem_priv));
      end
   end
`endif
`endif

endmodule

// File: tb/tb_hazard3_ifetch_ahbl.sv
module tb_hazard3_ifetch_ahbl;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   hazard3_ifetch_ahbl_if #(.W_ADDR(32), .W_DATA(32)) bus ();

   hazard3_ifetch_ahbl #(.W_ADDR(32), .W_DATA(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [31:0] addr, input logic size,
                        input logic priv, input logic hready, input logic hresp,
                        input logic [31:0] hrdata);
      bus.mem_addr_vld = vld;
      bus.mem_addr     = addr;
      bus.mem_size     = size;
      bus.mem_priv     = priv;
      bus.i_hready     = hready;
      bus.i_hresp      = hresp;
      bus.i_hrdata     = hrdata;
   endtask

   // One bus cycle: drive just after the rising edge, leave time to settle.
   task automatic cyc(input logic vld, input logic [31:0] addr, input logic size,
                      input logic priv, input logic hready, input logic hresp,
                      input logic [31:0] hrdata);
      @(posedge clk);
      #1;
      drive(vld, addr, size, priv, hready, hresp, hrdata);
      #4;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      #12;
      chk("rst_htrans", {30'd0, bus.i_htrans}, 32'd0);
      chk("rst_haddr", bus.i_haddr, 32'd0);
      chk("rst_rdy", {31'd0, bus.mem_addr_rdy}, 32'd0);
      chk("rst_dvld", {31'd0, bus.mem_data_vld}, 32'd0);
      chk("rst_derr", {31'd0, bus.mem_data_err}, 32'd0);
      chk("rst_data", bus.mem_data, 32'd0);
      chk("tie_hwrite", {31'd0, bus.i_hwrite}, 32'd0);
      chk("tie_hburst", {29'd0, bus.i_hburst}, 32'd0);
      chk("tie_hmastlock", {31'd0, bus.i_hmastlock}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single word fetch
      cyc(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("w_rdy", {31'd0, bus.mem_addr_rdy}, 32'd1);
      chk("w_htrans", {30'd0, bus.i_htrans}, 32'd2);
      chk("w_haddr", bus.i_haddr, 32'h40);
      chk("w_hsize", {29'd0, bus.i_hsize}, 32'd2);
      chk("w_hprot", {28'd0, bus.i_hprot}, 32'd2);
      chk("w_dvld0", {31'd0, bus.mem_data_vld}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
      chk("w_dvld", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("w_data", bus.mem_data, 32'h1234_5678);
      chk("w_derr", {31'd0, bus.mem_data_err}, 32'd0);
      chk("w_idle", {30'd0, bus.i_htrans}, 32'd0);

      // Four back-to-back halfword fetches, M-mode off
      for (int i = 0; i < 5; i++) begin
         cyc(i < 4, 32'h100 + 32'(2 * i), 1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i - 1));
         if (i < 4) begin
            chk("hw_htrans", {30'd0, bus.i_htrans}, 32'd2);
            chk("hw_haddr", bus.i_haddr, 32'h100 + 32'(2 * i));
            chk("hw_hsize", {29'd0, bus.i_hsize}, 32'd1);
            chk("hw_hprot", {28'd0, bus.i_hprot}, 32'd0);
            chk("hw_rdy", {31'd0, bus.mem_addr_rdy}, 32'd1);
         end
         if (i == 0) begin
            chk("hw_dvld0", {31'd0, bus.mem_data_vld}, 32'd0);
         end else begin
            chk("hw_dvld", {31'd0, bus.mem_data_vld}, 32'd1);
            chk("hw_data", bus.mem_data, 32'hA000_0000 + 32'(i - 1));
         end
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("hw_tail", {31'd0, bus.mem_data_vld}, 32'd0);

      // Wait states during data phase of 0x200, 0x204 pending
      cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("ws_rdy_a", {31'd0, bus.mem_addr_rdy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD0_0000);
         chk("ws_haddr", bus.i_haddr, 32'h204);
         chk("ws_htrans", {30'd0, bus.i_htrans}, 32'd2);
         chk("ws_rdy", {31'd0, bus.mem_addr_rdy}, 32'd0);
         chk("ws_dvld", {31'd0, bus.mem_data_vld}, 32'd0);
      end
      cyc(1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000);
      chk("ws_rdy_e", {31'd0, bus.mem_addr_rdy}, 32'd1);
      chk("ws_dvld_e", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("ws_data_e", bus.mem_data, 32'h0000_2000);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2004);
      chk("ws_dvld_f", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("ws_data_f", bus.mem_data, 32'h0000_2004);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("ws_dvld_g", {31'd0, bus.mem_data_vld}, 32'd0);

      // Two-cycle error response on 0x300, 0x304 waiting behind it
      cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("er_rdy_a", {31'd0, bus.mem_addr_rdy}, 32'd1);
      cyc(1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("er_htrans1", {30'd0, bus.i_htrans}, 32'd0);
      chk("er_haddr1", bus.i_haddr, 32'd0);
      chk("er_rdy1", {31'd0, bus.mem_addr_rdy}, 32'd0);
      chk("er_dvld1", {31'd0, bus.mem_data_vld}, 32'd0);
      cyc(1'b1, 32'h304, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
      chk("er_dvld2", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("er_derr2", {31'd0, bus.mem_data_err}, 32'd1);
      chk("er_htrans2", {30'd0, bus.i_htrans}, 32'd2);
      chk("er_haddr2", bus.i_haddr, 32'h304);
      chk("er_rdy2", {31'd0, bus.mem_addr_rdy}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3040);
      chk("er_dvld3", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("er_derr3", {31'd0, bus.mem_data_err}, 32'd0);
      chk("er_data3", bus.mem_data, 32'h0000_3040);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

`ifdef HAZARD3_IFETCH_ADDR_HOLD_EN
      // Held address phase; frontend switches from 0x400 to 0x800 mid-stall
      cyc(1'b1, 32'h3FC, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("hd_rdy_a", {31'd0, bus.mem_addr_rdy}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         chk("hd_haddr_st", bus.i_haddr, 32'h400);
         chk("hd_rdy_st", {31'd0, bus.mem_addr_rdy}, 32'd0);
      end
      cyc(1'b1, 32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("hd_haddr_sw", bus.i_haddr, 32'h400);
      chk("hd_rdy_sw", {31'd0, bus.mem_addr_rdy}, 32'd0);
      cyc(1'b1, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3FC0);
      chk("hd_haddr_e", bus.i_haddr, 32'h400);
      chk("hd_htrans_e", {30'd0, bus.i_htrans}, 32'd2);
      chk("hd_rdy_e", {31'd0, bus.mem_addr_rdy}, 32'd0);
      chk("hd_dvld_e", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("hd_data_e", bus.mem_data, 32'h0000_3FC0);
      cyc(1'b1, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
      chk("hd_orphan", {31'd0, bus.mem_data_vld}, 32'd0);
      chk("hd_haddr_f", bus.i_haddr, 32'h800);
      chk("hd_rdy_f", {31'd0, bus.mem_addr_rdy}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_8000);
      chk("hd_dvld_g", {31'd0, bus.mem_data_vld}, 32'd1);
      chk("hd_data_g", bus.mem_data, 32'h0000_8000);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
`endif

      // Reset asserted during a stalled data phase
      cyc(1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("rs_rdy_a", {31'd0, bus.mem_addr_rdy}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_5555);
      chk("rs_dvld_b", {31'd0, bus.mem_data_vld}, 32'd0);
      rst_n = 1'b0;
      bus.i_hready = 1'b1;
      #1;
      chk("rs_htrans", {30'd0, bus.i_htrans}, 32'd0);
      chk("rs_dvld", {31'd0, bus.mem_data_vld}, 32'd0);
      chk("rs_data", bus.mem_data, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5555_5555);
      chk("rs_stale", {31'd0, bus.mem_data_vld}, 32'd0);
      chk("rs_idle", {30'd0, bus.i_htrans}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
